ctrl_decode_pipe: RTL
=====================

# ctrl_decode_pipe

Registered, parametrised main-control decoder for the MIPS datapath. It decodes the 6-bit opcode of each valid instruction into the full control bundle and carries that bundle through `STAGES` pipeline registers with valid, stall and flush. It also flags illegal opcodes and counts them in a saturating counter. It sits between instruction fetch and the execute-stage control consumers.

## Interface
- `STAGES`, 1: number of control register stages, legal range 1..4.
- `CNT_W`, 8: width of the illegal-opcode counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: `op` carries a valid instruction.
- `op` in 6: instruction[31:26].
- `stall` in 1: hold every stage.
- `flush` in 1: kill every stage.
- `cnt_clr` in 1: clear the illegal counter.
- `out_valid` out 1: the output stage holds a valid instruction.
- `regwrite`, `regdst`, `alusrc`, `branch`, `memwrite`, `memtoreg`, `jump`, `hassign`, `islui` out 1 each: control bits.
- `aluop` out 3: ALU operation code.
- `mem_op` out 3: memory access width and sign.
- `branch_ne`, `link` out 1 each: extended control bits, see Configuration.
- `illegal` out 1: the output stage holds an undecodable opcode.
- `ill_cnt` out `CNT_W`: count of illegal opcodes accepted.

## Operation
- Decoding is combinational on `op`. Fields are listed as regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump / aluop / hassign, islui / mem_op.
- R-type 000000: 1100000/010/00/000.
- LW 100011: 1010010/000/00/000.
- SW 101011: 0010100/000/00/000.
- BEQ 000100: 0001000/001/00/000.
- ADDI 001000 and ADDIU 001001: 1010000/000/00/000.
- LUI 001111: 1010000/000/01/000.
- J 000010: 0000001/000/00/000.
- Loads 1010010/000/00, with mem_op: LB 100000→110, LBU 100100→111, LH 100001→100, LHU 100101→101.
- Stores 0010100/000/00, with mem_op: SB 101000→010, SH 101001→001.
- Immediate ALU ops, all 1010000: SLTI 001010→011/10, SLTIU 001011→011/00, ANDI 001100→100/00, ORI 001101→101/00, XORI 001110→110/00.
- Any other opcode: all control bits 0 and `illegal`=1.
- aluop codes: 000 add, 001 sub, 010 use funct, 011 set-less-than, 100 and, 101 or, 110 xor.
- Stage 1 loads {`in_valid`, decoded bundle, illegal}. Stage k loads from stage k-1. Outputs come from stage `STAGES`.
- Bubble rule: when a stage's valid is 0, all its control bits and `illegal` are 0. A bubble therefore never writes a register or memory.
- Accept event = `in_valid & ~stall & ~flush`. An accept with an illegal opcode increments `ill_cnt`, saturating at 2^CNT_W−1.
- Counter precedence: `cnt_clr` sets the counter to 0 and wins over a same-cycle increment.

## Timing
- Reset: every stage valid=0, every control output 0, `out_valid`=0, `illegal`=0, `ill_cnt`=0.
- Latency: an opcode accepted at edge N is visible on the outputs after edge N+STAGES−1.
- Throughput is one instruction per cycle.
- `stall`=1: all stages hold and the counter does not increment.
- `flush`=1: all stage valids clear on the next edge and the counter does not increment. Flush beats stall.
- Reset beats flush, stall and `cnt_clr`. Reset mid-stream discards every in-flight instruction.
- `in_valid`=0 with no stall inserts a bubble.

## Configuration
- Macro `DECODE_EXT_EN`.
- Defined:
  - BNE 000101 decodes as 0001000/001/00/000 with `branch_ne`=1.
  - JAL 000011 decodes as 1000001/000/00/000 with `link`=1. Downstream writes r31.
- Undefined:
  - 000101 and 000011 are illegal.
  - `branch_ne` and `link` are tied 0.

## Test plan
- Reset, then STAGES=2: drive LW (100011) at cycle 0 → on the outputs after edge 1, `out_valid`=1, regwrite=1, alusrc=1, memtoreg=1, mem_op=000.
- Back-to-back SB, SLTI, ORI with no stall → successive output cycles show mem_op=010; then aluop=011 with hassign=1; then aluop=101.
- Illegal op 111111 on 3 accepts, then 300 more with CNT_W=8 → `illegal`=1 at the outputs; `ill_cnt` reaches 3, then saturates at 255. `cnt_clr` together with an illegal accept → 0.
- Stall held 3 cycles with in_valid=1 and a 6'b111111 opcode → outputs frozen, `ill_cnt` unchanged; simultaneous stall+flush → `out_valid`=0 after STAGES edges.
- Flush while a SW is in stage 1 → the SW never appears, memwrite stays 0.
- BNE 000101: with `DECODE_EXT_EN` → branch=1, `branch_ne`=1, `illegal`=0. Without it → `illegal`=1 and `ill_cnt` increments.

Source files
------------

// File: rtl/ctrl_decode_pipe.sv
// Registered MIPS main-control decoder with a STAGES-deep valid/stall/flush pipeline
// and a saturating illegal-opcode counter. Build macro DECODE_EXT_EN adds BNE and JAL.
module ctrl_decode_pipe #(
    parameter int STAGES = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [5:0]       op,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             regwrite,
    output logic             regdst,
    output logic             alusrc,
    output logic             branch,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             jump,
    output logic             hassign,
    output logic             islui,
    output logic [2:0]       aluop,
    output logic [2:0]       mem_op,
    output logic             branch_ne,
    output logic             link,
    output logic             illegal,
    output logic [CNT_W-1:0] ill_cnt
);

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [2:0] aluop;
        logic       hassign;
        logic       islui;
        logic [2:0] mem_op;
`ifdef DECODE_EXT_EN
        logic       branch_ne;
        logic       link;
`endif
        logic       illegal;
    } ctrl_t;

    // Builds a legal bundle; field order matches the opcode table
    // (regwrite..jump / aluop / hassign,islui / mem_op).
    function automatic ctrl_t mk(input logic [6:0] bits, input logic [2:0] aop,
                                 input logic [1:0] hl, input logic [2:0] mop);
        ctrl_t c;
        c = '0;
        {c.regwrite, c.regdst, c.alusrc, c.branch, c.memwrite, c.memtoreg, c.jump} = bits;
        c.aluop   = aop;
        {c.hassign, c.islui} = hl;
        c.mem_op  = mop;
        c.illegal = 1'b0;
        return c;
    endfunction

    ctrl_t dec;

    always_comb begin
        dec = '0;
        case (op)
            6'b000000: dec = mk(7'b1100000, 3'b010, 2'b00, 3'b000);
            6'b100011: dec = mk(7'b1010010, 3'b000, 2'b00, 3'b000);
            6'b101011: dec = mk(7'b0010100, 3'b000, 2'b00, 3'b000);
            6'b000100: dec = mk(7'b0001000, 3'b001, 2'b00, 3'b000);
            6'b001000,
            6'b001001: dec = mk(7'b1010000, 3'b000, 2'b00, 3'b000);
            6'b001111: dec = mk(7'b1010000, 3'b000, 2'b01, 3'b000);
            6'b000010: dec = mk(7'b0000001, 3'b000, 2'b00, 3'b000);
            6'b100000: dec = mk(7'b1010010, 3'b000, 2'b00, 3'b110);
            6'b100100: dec = mk(7'b1010010, 3'b000, 2'b00, 3'b111);
            6'b100001: dec = mk(7'b1010010, 3'b000, 2'b00, 3'b100);
            6'b100101: dec = mk(7'b1010010, 3'b000, 2'b00, 3'b101);
            6'b101000: dec = mk(7'b0010100, 3'b000, 2'b00, 3'b010);
            6'b101001: dec = mk(7'b0010100, 3'b000, 2'b00, 3'b001);
            6'b001010: dec = mk(7'b1010000, 3'b011, 2'b10, 3'b000);
            6'b001011: dec = mk(7'b1010000, 3'b011, 2'b00, 3'b000);
            6'b001100: dec = mk(7'b1010000, 3'b100, 2'b00, 3'b000);
            6'b001101: dec = mk(7'b1010000, 3'b101, 2'b00, 3'b000);
            6'b001110: dec = mk(7'b1010000, 3'b110, 2'b00, 3'b000);
`ifdef DECODE_EXT_EN
            6'b000101: begin
                dec = mk(7'b0001000, 3'b001, 2'b00, 3'b000);
                dec.branch_ne = 1'b1;
            end
            6'b000011: begin
                dec = mk(7'b1000001, 3'b000, 2'b00, 3'b000);
                dec.link = 1'b1;
            end
`endif
            default:   dec.illegal = 1'b1;
        endcase
    end

    ctrl_t             stg_q [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;

    assign accept = in_valid & ~stall & ~flush;

    // Bubbles carry an all-zero bundle so nothing downstream can be written by them.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
        end else if (!stall) begin
            vld_q[0] <= in_valid;
            stg_q[0] <= in_valid ? dec : '0;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                stg_q[k] <= stg_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_q <= '0;
        end else if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign regwrite  = stg_q[STAGES-1].regwrite;
    assign regdst    = stg_q[STAGES-1].regdst;
    assign alusrc    = stg_q[STAGES-1].alusrc;
    assign branch    = stg_q[STAGES-1].branch;
    assign memwrite  = stg_q[STAGES-1].memwrite;
    assign memtoreg  = stg_q[STAGES-1].memtoreg;
    assign jump      = stg_q[STAGES-1].jump;
    assign aluop     = stg_q[STAGES-1].aluop;
    assign hassign   = stg_q[STAGES-1].hassign;
    assign islui     = stg_q[STAGES-1].islui;
    assign mem_op    = stg_q[STAGES-1].mem_op;
    assign illegal   = stg_q[STAGES-1].illegal;
    assign ill_cnt   = cnt_q;
`ifdef DECODE_EXT_EN
    assign branch_ne = stg_q[STAGES-1].branch_ne;
    assign link      = stg_q[STAGES-1].link;
`else
    assign branch_ne = 1'b0;
    assign link      = 1'b0;
`endif

endmodule
